// File: rtl/audio_pkg.sv
// Shared audio constants and the I2S channel encoding used by the receive path.
package audio_pkg;

   localparam int AUDIO_DATA_W = 24;
   localparam int I2S_SLOT_W   = 32;

   // 49.152 MHz system clock divided by a 48 kHz frame rate
   localparam int CLK_PER_FRAME = 1024;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } channel_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for the bit clock and its companion data lines, plus a
// history flop on the bit clock so its rising edge can be detected.
module i2s_sync_edge #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         edge_in,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] data_sync,
   output logic         rise
);

   logic [W-1:0] data_meta;
   logic [W-1:0] data_q;
   logic         edge_meta;
   logic         edge_q;
   logic         edge_hist;

   // Every line passes through the same two stages so data stays aligned with the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_meta <= '0;
         data_q    <= '0;
         edge_meta <= 1'b0;
         edge_q    <= 1'b0;
         edge_hist <= 1'b0;
      end else begin
         data_meta <= data_in;
         data_q    <= data_meta;
         edge_meta <= edge_in;
         edge_q    <= edge_meta;
         edge_hist <= edge_q;
      end
   end

   assign data_sync = data_q;
   assign rise      = edge_q & ~edge_hist;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA on clk, deserialises the left and
// right words of each frame and reports frame-length lock.
module i2s_rx
   import audio_pkg::*;
#(
   parameter int DATA_W      = AUDIO_DATA_W,
   parameter int SLOT_W      = I2S_SLOT_W,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i2s_bclk,
   input  logic              i2s_lrck,
   input  logic              i2s_sdata,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              sample_valid,
   output logic              locked,
   output logic              frame_err
);

   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [5:0]        IDX_MAX      = 6'd63;
   localparam logic [5:0]        IDX_WORD     = 6'(DATA_W);
   localparam logic [5:0]        IDX_SLOT_END = 6'(SLOT_W - 1);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT   = IDLE_W'(TIMEOUT_CYC);
   localparam logic [IDLE_W-1:0] IDLE_TRIP    = IDLE_W'(TIMEOUT_CYC - 1);

   logic [1:0]        data_sync;
   logic              bclk_rise;
   logic              lrck_s;
   logic              sdata_s;

   logic [5:0]        bit_idx;
   logic [5:0]        bit_nxt;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] word_nxt;
   logic [DATA_W-1:0] left_hold;
   logic              left_ok;
   logic [1:0]        good_cnt;
   logic              armed;
   channel_t          lrck_prev;
   logic [IDLE_W-1:0] idle_cnt;

   i2s_sync_edge #(
      .W(2)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .edge_in  (i2s_bclk),
      .data_in  ({i2s_sdata, i2s_lrck}),
      .data_sync(data_sync),
      .rise     (bclk_rise)
   );

   assign lrck_s   = data_sync[0];
   assign sdata_s  = data_sync[1];
   assign bit_nxt  = (bit_idx == IDX_MAX) ? IDX_MAX : bit_idx + 6'd1;
   assign word_nxt = {shift_reg[DATA_W-2:0], sdata_s};

   // Slot tracking, capture, lock qualification and activity timeout all share
   // one register block; a detected bit-clock edge always takes priority over timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_idx      <= '0;
         shift_reg    <= '0;
         left_hold    <= '0;
         left_ok      <= 1'b0;
         good_cnt     <= '0;
         armed        <= 1'b0;
         lrck_prev    <= CH_LEFT;
         idle_cnt     <= '0;
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         locked       <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         if (bclk_rise) begin
            idle_cnt <= '0;
            if (lrck_s != lrck_prev) begin
               if (!armed) begin
                  armed <= 1'b1;
               end else if (bit_idx == IDX_SLOT_END) begin
                  if (good_cnt != 2'd2) good_cnt <= good_cnt + 2'd1;
                  if (good_cnt != 2'd0) locked <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
                  good_cnt  <= '0;
                  locked    <= 1'b0;
                  left_ok   <= 1'b0;
               end
               bit_idx   <= '0;
               lrck_prev <= channel_t'(lrck_s);
            end else begin
               bit_idx <= bit_nxt;
               if (bit_nxt <= IDX_WORD) shift_reg <= word_nxt;
               // A left word only counts toward a sample if it was captured while locked
               if (bit_nxt == IDX_WORD) begin
                  if (lrck_prev == CH_LEFT) begin
                     left_hold <= word_nxt;
                     left_ok   <= locked;
                  end else begin
                     if (locked && left_ok) begin
                        right_data   <= word_nxt;
                        left_data    <= left_hold;
                        sample_valid <= 1'b1;
                     end
                     left_ok <= 1'b0;
                  end
               end
            end
         end else begin
            if (idle_cnt != IDLE_LIMIT) idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IDLE_TRIP) begin
               locked   <= 1'b0;
               armed    <= 1'b0;
               good_cnt <= '0;
               left_ok  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: lock, capture, short slot, clock stop, reset and jitter.
module tb_i2s_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i2s_bclk;
   logic        i2s_lrck;
   logic        i2s_sdata;
   logic [23:0] left_data;
   logic [23:0] right_data;
   logic        sample_valid;
   logic        locked;
   logic        frame_err;

   int check_cnt = 0;
   int fail_cnt  = 0;
   int cyc       = 0;

   int          valid_cnt      = 0;
   int          last_valid_cyc = 0;
   int          prev_valid_cyc = 0;
   logic [23:0] got_left       = '0;
   logic [23:0] got_right      = '0;
   int          err_cnt        = 0;
   int          err_wide       = 0;
   logic        err_prev       = 1'b0;
   logic        lock_prev      = 1'b0;
   int          lock_fall_cyc  = -1;
   int          last_rise_cyc  = 0;

   int v0;
   int e0;

   i2s_rx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrck    (i2s_lrck),
      .i2s_sdata   (i2s_sdata),
      .left_data   (left_data),
      .right_data  (right_data),
      .sample_valid(sample_valid),
      .locked      (locked),
      .frame_err   (frame_err)
   );

   // 10 ns system clock with a cycle counter for latency measurements
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Observe DUT pulses away from the active edge
   always @(negedge clk) begin
      if (sample_valid) begin
         valid_cnt++;
         prev_valid_cyc = last_valid_cyc;
         last_valid_cyc = cyc;
         got_left       = left_data;
         got_right      = right_data;
      end
      if (frame_err) begin
         err_cnt++;
         if (err_prev) err_wide++;
      end
      err_prev = frame_err;
      if (lock_prev && !locked) lock_fall_cyc = cyc;
      lock_prev = locked;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_left"}, 32'(left_data), 32'h0);
      checkOutput({tag, "_right"}, 32'(right_data), 32'h0);
      checkOutput({tag, "_valid"}, 32'(sample_valid), 32'h0);
      checkOutput({tag, "_locked"}, 32'(locked), 32'h0);
      checkOutput({tag, "_ferr"}, 32'(frame_err), 32'h0);
   endtask

   function automatic logic slot_bit(input logic [23:0] w, input int i, input logic pad);
      if (i >= 1 && i <= 24) return w[24-i];
      return pad;
   endfunction

   task automatic send_bit(input logic lr, input logic d, input int lo, input int hi);
      i2s_bclk  = 1'b0;
      i2s_lrck  = lr;
      i2s_sdata = d;
      repeat (lo) @(negedge clk);
      i2s_bclk      = 1'b1;
      last_rise_cyc = cyc;
      repeat (hi) @(negedge clk);
   endtask

   task automatic pulse_reset();
      i2s_bclk = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkResetOutputs("midreset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One frame: left slot of 32 bits, right slot of rlen bits, optional reset before bit rst_bit
   task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input logic pad,
                                input int rlen, input int lo, input int hi, input int rst_bit);
      for (int i = 0; i < 32; i++) begin
         if (i == rst_bit) pulse_reset();
         send_bit(1'b0, slot_bit(l, i, pad), lo, hi);
      end
      for (int i = 0; i < rlen; i++) send_bit(1'b1, slot_bit(r, i, pad), lo, hi);
   endtask

   initial begin
      rst_n     = 1'b0;
      i2s_bclk  = 1'b0;
      i2s_lrck  = 1'b0;
      i2s_sdata = 1'b0;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] lock acquisition and basic capture");
      applyStimulus(24'h123456, 24'hABCDEF, 1'b0, 32, 8, 8, -1);
      checkOutput("f1_no_valid", 32'(valid_cnt), 32'd0);
      applyStimulus(24'h123456, 24'hABCDEF, 1'b0, 32, 8, 8, -1);
      checkOutput("f2_no_valid", 32'(valid_cnt), 32'd0);
      checkOutput("f2_locked", 32'(locked), 32'd1);
      applyStimulus(24'h123456, 24'hABCDEF, 1'b0, 32, 8, 8, -1);
      checkOutput("f3_valid", 32'(valid_cnt), 32'd1);
      checkOutput("f3_left", 32'(got_left), 32'h123456);
      checkOutput("f3_right", 32'(got_right), 32'hABCDEF);

      $display("[TB] full scale with padding driven high");
      applyStimulus(24'h7FFFFF, 24'h800000, 1'b1, 32, 8, 8, -1);
      checkOutput("fs_valid", 32'(valid_cnt), 32'd2);
      checkOutput("fs_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd1024);
      checkOutput("fs_left", 32'(got_left), 32'h7FFFFF);
      checkOutput("fs_right", 32'(got_right), 32'h800000);
      checkOutput("fs_no_ferr", 32'(err_cnt), 32'd0);

      $display("[TB] short right slot and recovery");
      applyStimulus(24'h111111, 24'h222222, 1'b0, 31, 8, 8, -1);
      v0 = valid_cnt;
      applyStimulus(24'h333333, 24'h444444, 1'b0, 32, 8, 8, -1);
      checkOutput("short_ferr_cnt", 32'(err_cnt), 32'd1);
      checkOutput("short_ferr_width", 32'(err_wide), 32'd0);
      checkOutput("short_unlocked", 32'(locked), 32'd0);
      checkOutput("short_no_valid", 32'(valid_cnt - v0), 32'd0);
      applyStimulus(24'h0F0F0F, 24'h3C3C3C, 1'b0, 32, 8, 8, -1);
      checkOutput("relock", 32'(locked), 32'd1);
      checkOutput("relock_valid", 32'(valid_cnt - v0), 32'd1);
      checkOutput("relock_left", 32'(got_left), 32'h0F0F0F);
      checkOutput("relock_right", 32'(got_right), 32'h3C3C3C);

      $display("[TB] bit clock stop");
      v0            = valid_cnt;
      e0            = err_cnt;
      lock_fall_cyc = -1;
      i2s_bclk      = 1'b0;
      repeat (100) @(negedge clk);
      checkOutput("stop_fall_delay", 32'(lock_fall_cyc - last_rise_cyc), 32'd67);
      checkOutput("stop_unlocked", 32'(locked), 32'd0);
      checkOutput("stop_no_ferr", 32'(err_cnt - e0), 32'd0);
      checkOutput("stop_left_held", 32'(left_data), 32'h0F0F0F);
      checkOutput("stop_right_held", 32'(right_data), 32'h3C3C3C);

      $display("[TB] reset in the middle of a left slot");
      v0 = valid_cnt;
      applyStimulus(24'h555555, 24'h666666, 1'b0, 32, 8, 8, 10);
      checkOutput("rst_fr1_no_valid", 32'(valid_cnt - v0), 32'd0);
      applyStimulus(24'h777777, 24'h888888, 1'b0, 32, 8, 8, -1);
      checkOutput("rst_fr2_no_valid", 32'(valid_cnt - v0), 32'd0);
      applyStimulus(24'h654321, 24'h0BEEF0, 1'b0, 32, 8, 8, -1);
      checkOutput("rst_fr3_valid", 32'(valid_cnt - v0), 32'd1);
      checkOutput("rst_fr3_left", 32'(got_left), 32'h654321);
      checkOutput("rst_fr3_right", 32'(got_right), 32'h0BEEF0);

      $display("[TB] jittered bit clock");
      v0 = valid_cnt;
      e0 = err_cnt;
      applyStimulus(24'hA5A5A5, 24'h5A5A5A, 1'b0, 32, 4, 12, -1);
      checkOutput("jit1_locked", 32'(locked), 32'd1);
      checkOutput("jit1_left", 32'(got_left), 32'hA5A5A5);
      checkOutput("jit1_right", 32'(got_right), 32'h5A5A5A);
      applyStimulus(24'h000001, 24'hFFFFFE, 1'b0, 32, 4, 12, -1);
      checkOutput("jit2_locked", 32'(locked), 32'd1);
      checkOutput("jit2_left", 32'(got_left), 32'h000001);
      checkOutput("jit2_right", 32'(got_right), 32'hFFFFFE);
      checkOutput("jit_valid_cnt", 32'(valid_cnt - v0), 32'd2);
      checkOutput("jit_no_ferr", 32'(err_cnt - e0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
      $finish;
   end

endmodule
